// File: rtl/lib_pipe.sv
// lib_pipe: WIDTH-bit delay line of STAGES registers with asynchronous active-low reset.
// Define LIB_PIPE_PRIMED_EN to add out_primed, high once every stage holds post-reset data.
module lib_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_bus,
`ifdef LIB_PIPE_PRIMED_EN
  output logic             out_primed,
`endif
  output logic [WIDTH-1:0] out_bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("lib_pipe: WIDTH must be 1 or more");
  end
  if (STAGES < 0) begin : g_bad_stages
    $error("lib_pipe: STAGES must be 0 or more");
  end

  if (STAGES <= 0) begin : g_wire
    // Zero-stage pipe is a plain wire; reset cannot touch it.
    assign out_bus = in_bus;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
      stage_d[0] = in_bus;
      for (int k = 1; k < STAGES; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < STAGES; k++) begin
          stage_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < STAGES; k++) begin
          stage_q[k] <= stage_d[k];
        end
      end
    end

    assign out_bus = stage_q[STAGES-1];
  end

`ifdef LIB_PIPE_PRIMED_EN
  if (STAGES <= 0) begin : g_primed_const
    assign out_primed = 1'b1;
  end else begin : g_primed_cnt
    localparam int CW = $clog2(STAGES + 1);
    logic [CW-1:0] fill_cnt_q;
    logic [CW-1:0] fill_cnt_d;

    // Counts edges since release, saturating once the last stage has been written.
    always_comb begin
      fill_cnt_d = fill_cnt_q;
      if (fill_cnt_q != CW'(STAGES)) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fill_cnt_q <= '0;
      end else begin
        fill_cnt_q <= fill_cnt_d;
      end
    end

    assign out_primed = (fill_cnt_q == CW'(STAGES));
  end
`endif

endmodule

// File: tb/tb_lib_pipe.sv
// Directed self-checking bench for lib_pipe across several WIDTH/STAGES configurations.
// Exercises out_primed as well when LIB_PIPE_PRIMED_EN is defined.
module tb_lib_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0, rst_e = 1'b0;
  logic [7:0]  in_a = '0, out_a;
  logic [0:0]  in_b = '0, out_b;
  logic [15:0] in_c = '0, out_c;
  logic [3:0]  in_d = '0, out_d;
  logic [7:0]  in_e = '0, out_e;
`ifdef LIB_PIPE_PRIMED_EN
  logic prm_a, prm_b, prm_c, prm_d, prm_e;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  lib_pipe #(.WIDTH(8), .STAGES(3)) u_a (
    .clk(clk), .rst_n(rst_a), .in_bus(in_a),
`ifdef LIB_PIPE_PRIMED_EN
    .out_primed(prm_a),
`endif
    .out_bus(out_a));

  lib_pipe #(.WIDTH(1), .STAGES(0)) u_b (
    .clk(clk), .rst_n(rst_b), .in_bus(in_b),
`ifdef LIB_PIPE_PRIMED_EN
    .out_primed(prm_b),
`endif
    .out_bus(out_b));

  lib_pipe #(.WIDTH(16), .STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_c), .in_bus(in_c),
`ifdef LIB_PIPE_PRIMED_EN
    .out_primed(prm_c),
`endif
    .out_bus(out_c));

  lib_pipe #(.WIDTH(4), .STAGES(5)) u_d (
    .clk(clk), .rst_n(rst_d), .in_bus(in_d),
`ifdef LIB_PIPE_PRIMED_EN
    .out_primed(prm_d),
`endif
    .out_bus(out_d));

  lib_pipe #(.WIDTH(8), .STAGES(4)) u_e (
    .clk(clk), .rst_n(rst_e), .in_bus(in_e),
`ifdef LIB_PIPE_PRIMED_EN
    .out_primed(prm_e),
`endif
    .out_bus(out_e));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pat_d(input int n);
    return 4'((n * 5) + (n >> 2) + 3);
  endfunction

  logic [7:0]  a_in  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
  logic [7:0]  a_exp [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
  logic [15:0] c_exp [4] = '{16'h0000, 16'h1234, 16'h1234, 16'h1234};

  initial begin
    repeat (2) tick();

    check_val("a_rst_state", 32'(out_a), 32'h0);
    check_val("c_rst_state", 32'(out_c), 32'h0);
    check_val("d_rst_state", 32'(out_d), 32'h0);

    // Zero-stage pipe under reset: pure wire, no clock involved.
    in_b = 1'b0; #1 check_val("b_wire_0", 32'(out_b), 32'h0);
    in_b = 1'b1; #1 check_val("b_wire_1", 32'(out_b), 32'h1);
    in_b = 1'b0; #1 check_val("b_wire_0b", 32'(out_b), 32'h0);
    in_b = 1'b1; #1 check_val("b_wire_1b", 32'(out_b), 32'h1);

    // WIDTH=8 STAGES=3 basic latency and order.
    rst_a = 1'b1;
    #1 check_val("a_post_release", 32'(out_a), 32'h0);
    for (int i = 0; i < 6; i++) begin
      in_a = a_in[i];
      tick();
      check_val($sformatf("a_edge%0d", i + 1), 32'(out_a), 32'(a_exp[i]));
    end

    // WIDTH=16 STAGES=2 asynchronous reset discards in-flight data.
    rst_c = 1'b1;
    in_c = 16'hBEEF;
    tick();
    check_val("c_edge1", 32'(out_c), 32'h0);
    in_c = 16'h1234;
    tick();
    check_val("c_edge2_beef", 32'(out_c), 32'hBEEF);
    #2 rst_c = 1'b0;
    #1 check_val("c_async_clear", 32'(out_c), 32'h0);
    tick();
    check_val("c_hold_in_reset", 32'(out_c), 32'h0);
    #2 rst_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("c_after_rel%0d", i + 1), 32'(out_c), 32'(c_exp[i]));
    end

    // WIDTH=4 STAGES=5 long stream, out after edge n is input sampled at edge n-4.
    rst_d = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      in_d = pat_d(n);
      tick();
      check_val($sformatf("d_edge%0d", n), 32'(out_d), (n >= 5) ? 32'(pat_d(n - 4)) : 32'h0);
    end

    // WIDTH=8 STAGES=4 data path sanity, plus out_primed when present.
`ifdef LIB_PIPE_PRIMED_EN
    check_val("b_primed_const", 32'(prm_b), 32'h1);
    check_val("a_primed", 32'(prm_a), 32'h1);
    check_val("e_primed_rst", 32'(prm_e), 32'h0);
`endif
    rst_e = 1'b1;
    in_e = 8'h5A;
    for (int n = 1; n <= 6; n++) begin
      tick();
      in_e = 8'h00;
`ifdef LIB_PIPE_PRIMED_EN
      check_val($sformatf("e_primed_edge%0d", n), 32'(prm_e), (n >= 4) ? 32'h1 : 32'h0);
`endif
      check_val($sformatf("e_data_edge%0d", n), 32'(out_e), (n == 4) ? 32'h5A : 32'h0);
    end
    #2 rst_e = 1'b0;
`ifdef LIB_PIPE_PRIMED_EN
    #1 check_val("e_primed_drop", 32'(prm_e), 32'h0);
`else
    #1 check_val("e_rst_clear", 32'(out_e), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
